// File: rtl/fir_sample_feeder.sv
// FIR upstream feeder: buffers ADC samples in a small FIFO and strobes
// them to the filter one at a time, pacing on the filter's dav pulse.
`timescale 1ns/1ps
module fir_sample_feeder #(
  parameter int SampleWidth    = 8,
  parameter int FifoDepth      = 4,
  parameter int FifoAddrsWidth = 2,
  parameter int InitCycles     = 10,
  parameter int TimeoutWidth   = 6,
  parameter int TimeoutCycles  = 40
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic [SampleWidth-1:0]  inSample,
  input  logic                    inValid,
  output logic [SampleWidth-1:0]  sample,
  output logic                    sampleClk,
  input  logic                    dav,
  output logic [FifoAddrsWidth:0] level,
  output logic                    overflow,
  output logic                    timeoutErr
);

  localparam int InitWidth = $clog2(InitCycles + 1);
  localparam int LevelWidth = FifoAddrsWidth + 1;

  typedef enum logic [1:0] {
    waitInit,
    ready,
    busy
  } state_t;

  state_t state, stateNext;

  logic [SampleWidth-1:0]    mem [FifoDepth];
  logic [FifoAddrsWidth-1:0] wrPtr, rdPtr;
  logic [InitWidth-1:0]      initCnt, initCntNext;
  logic [TimeoutWidth-1:0]   wdCnt, wdCntNext;
  logic full, empty;
  logic pop, push, drop, timeoutHit;

  assign full  = (level == LevelWidth'(FifoDepth));
  assign empty = (level == '0);

  // Pop decision uses pre-edge occupancy, so a fresh push is never bypassed.
  assign push = inValid && (!full || pop);
  assign drop = inValid && full && !pop;

  always_comb begin
    stateNext   = state;
    initCntNext = initCnt;
    wdCntNext   = wdCnt;
    pop         = 1'b0;
    timeoutHit  = 1'b0;
    unique case (state)
      waitInit: begin
        if (initCnt == InitWidth'(InitCycles - 1)) begin
          stateNext = ready;
        end else begin
          initCntNext = initCnt + 1'b1;
        end
      end
      ready: begin
        if (!empty) begin
          pop       = 1'b1;
          stateNext = busy;
        end
      end
      busy: begin
        if (dav) begin
          wdCntNext = '0;
          stateNext = ready;
        end else if (wdCnt == TimeoutWidth'(TimeoutCycles - 1)) begin
          timeoutHit = 1'b1;
          wdCntNext  = '0;
          stateNext  = ready;
        end else begin
          wdCntNext = wdCnt + 1'b1;
        end
      end
      default: stateNext = waitInit;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= waitInit;
      initCnt    <= '0;
      wdCnt      <= '0;
      wrPtr      <= '0;
      rdPtr      <= '0;
      level      <= '0;
      sample     <= '0;
      sampleClk  <= 1'b0;
      overflow   <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      state     <= stateNext;
      initCnt   <= initCntNext;
      wdCnt     <= wdCntNext;
      sampleClk <= pop;
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) begin
        rdPtr  <= rdPtr + 1'b1;
        sample <= mem[rdPtr];
      end
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop) overflow <= 1'b1;
      if (timeoutHit) timeoutErr <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= inSample;
  end

endmodule

// File: doc/fir_sample_feeder.md
# fir_sample_feeder

Upstream stage of the FIR filter. It accepts a free-running sample stream from the ADC side, buffers it in a small FIFO, and hands samples to the filter one at a time. For each sample it drives `sample` with a one-cycle `sampleClk` strobe, then waits for the filter's `dav` before issuing the next one. It also holds off after reset until the filter's RAM initialisation has finished, and flags dropped samples and filter hangs.

## Interface
Parameters:
- `SampleWidth`, 8: width of the sample path; must match the filter.
- `FifoDepth`, 4: FIFO entries; must be a power of two.
- `FifoAddrsWidth`, 2: log2(`FifoDepth`).
- `InitCycles`, 10: cycles to hold off after reset while the filter clears its RAM; ≥ the filter's tap count.
- `TimeoutWidth`, 6: width of the busy watchdog counter.
- `TimeoutCycles`, 40: busy cycles without `dav` before abort; must be < 2^`TimeoutWidth`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `resetN`  in  1: asynchronous, active-low reset.
- `inSample`  in  `SampleWidth`: incoming sample.
- `inValid`  in  1: `inSample` valid this cycle; the source cannot stall.
- `sample`  out  `SampleWidth`: sample presented to the filter (registered).
- `sampleClk`  out  1: one-cycle strobe; `sample` is valid while it is high (registered).
- `dav`  in  1: filter result-valid pulse; marks the filter as back in idle.
- `level`  out  `FifoAddrsWidth`+1: current FIFO occupancy, 0..`FifoDepth`.
- `overflow`  out  1: sticky; a sample was dropped because the FIFO was full.
- `timeoutErr`  out  1: sticky; the filter failed to return `dav` within `TimeoutCycles`.

## Operation
- FIFO: circular buffer with write pointer, read pointer and a `FifoAddrsWidth`+1 occupancy count.
  - Push when `inValid` and (not full, or a pop happens in the same cycle).
  - `inValid` while full with no pop: the sample is discarded, `overflow` is set, FIFO contents are unchanged.
  - Simultaneous push and pop: `level` is unchanged and both pointers advance.
  - No bypass: a sample pushed at edge k cannot be popped before edge k+1.
- FSM states: `waitInit`, `ready`, `busy`.
  - `waitInit`: count `InitCycles` cycles from reset release, then go to `ready`. The FIFO still accepts pushes in this state.
  - `ready`: if FIFO non-empty, pop the head into `sample`, set `sampleClk`=1 and go to `busy`. Otherwise stay in `ready`.
  - `busy`: `sampleClk`=0 and the watchdog increments.
    - `dav`=1: clear the watchdog and go to `ready`.
    - Watchdog reaches `TimeoutCycles`-1 without `dav`: set `timeoutErr`, clear the watchdog, go to `ready`. The sample is not re-sent.
  - `dav` outside `busy` is ignored.
- `sample` holds its last value between strobes.
- Sticky flags clear only on reset.

## Timing
- Reset values: `sample`=0, `sampleClk`=0, `level`=0, `overflow`=0, `timeoutErr`=0. State is `waitInit`, pointers and counters are 0.
- First strobe can rise no earlier than `InitCycles`+1 edges after `resetN` deasserts.
- Latency from push into an empty FIFO while in `ready`:
  - push at edge k;
  - `sampleClk` high during the cycle after edge k+1, for exactly one cycle.
- `dav` sampled high at edge j causes the next strobe, if the FIFO is non-empty, at edge j+1. The minimum issue period is therefore the filter's compute time + 2 cycles.
- `level` updates on the edge that performs a push or pop.
- `overflow` rises on the edge that drops a sample.
- Reset asserted mid-`busy`: all outputs return to their reset values immediately and FIFO contents are discarded.

## Test plan
- Reset, then push 0x12 at cycle 2 → no `sampleClk` before `InitCycles`+1 edges; afterwards one strobe with `sample`=0x12, then `level`=0.
- In `ready` with FIFO empty, push 0x7F → `sampleClk` high for exactly one cycle, 2 edges after the push; no further strobe until `dav` pulses.
- Push 0x01, 0x02, 0x03 back-to-back, `dav` 12 cycles after each strobe → strobes carry 0x01, 0x02, 0x03 in order, each exactly 1 edge after the previous `dav`.
- Hold `dav` low and push 6 samples → `level` saturates at 4, `overflow`=1, the first 4 samples are retained in order. Later pushes in the same cycle as a pop are accepted without setting `overflow`.
- Hold `dav` low after a strobe → `timeoutErr`=1 after 40 busy cycles; the next queued sample strobes on the following edge.
- Assert `resetN`=0 mid-`busy` with `level`=3 → all outputs go to 0 immediately; after release the `waitInit` hold-off repeats.
